// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arb_pkg: shared widths, watchdog default and FSM encoding. Rev 1.0
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF         = 32;
  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_FETCH = 2'd1;
  localparam arb_state_t ST_DATA  = 2'd2;

  function automatic logic is_busy(input arb_state_t s);
    return (s == ST_FETCH) || (s == ST_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if: requester and memory-side bus bundle. Rev 1.0
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              flush;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              bus_err;

  // master is the arbiter itself; slave is the surrounding pipeline + memory
  modport master (
    input  if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport slave (
    output if_req, if_addr, flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arb_watchdog: flags an access that waits TIMEOUT_CYCLES without ack. Rev 1.0
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ack,
  output logic expire
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is the number of completed ack-less cycles of the current access
  always_comb begin
    cnt_d = '0;
    if (enable && !ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expire = enable && !ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// unified_mem_arbiter: shares one memory port between IF and MEM, data first.
// Watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.            Rev 1.0
// -----------------------------------------------------------------------------
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  unified_mem_arbiter_if.master bus
);
  arb_state_t        state_q, state_d;
  logic              kill_q, kill_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              bus_err_q, bus_err_d;

  logic busy;
  logic expire;
  logic done;
  logic if_valid;
  logic d_valid;

  assign busy = is_busy(state_q);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (busy),
    .ack    (bus.mem_ack),
    .expire (expire)
  );
  assign bus_err_d = bus_err_q | expire;
`else
  assign expire    = 1'b0;
  assign bus_err_d = 1'b0;
`endif

  // An access ends either on ack or on watchdog abort; both release the port.
  assign done = busy & (bus.mem_ack | expire);

  always_comb begin
    state_d     = state_q;
    kill_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.d_req) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else if (state_q == ST_FETCH) begin
          kill_d = kill_q | bus.flush;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A flush in the ack cycle itself must also suppress the fetch result.
  assign if_valid = (state_q == ST_FETCH) & done & ~kill_q & ~bus.flush;
  assign d_valid  = (state_q == ST_DATA) & done;

  assign bus.if_valid  = if_valid;
  assign bus.d_valid   = d_valid;
  assign bus.if_rdata  = (if_valid & bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (d_valid & bus.mem_ack & ~mem_we_q) ? bus.mem_rdata : '0;
  assign bus.if_stall  = bus.if_req & ~if_valid;
  assign bus.d_stall   = bus.d_req & ~d_valid;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_err   = bus_err_q;
endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter: scoreboard bench for the unified memory arbiter. Rev 1.0
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t        exp_q[$];
  obs_t        mem_q[$];
  int          errors = 0;
  int          checks = 0;
  int          wait_states = 0;
  bit          hang = 1'b0;
  logic [31:0] rd_value = '0;
  int          mem_cyc = 0;

  // Memory model: acks after wait_states cycles of mem_req, logs what it saw.
  always @(posedge clk or posedge rst) begin
    obs_t o;
    #1;
    if (rst || (bus.mem_req !== 1'b1)) begin
      bus.mem_ack = 1'b0;
      mem_cyc     = 0;
    end else begin
      if (!hang && mem_cyc == wait_states) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd_value;
        o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
        mem_q.push_back(o);
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
      mem_cyc++;
    end
  end

  task automatic wait_valid(input bit is_d, input int budget, output int cyc);
    int i = 0;
    cyc = -1;
    while (cyc < 0 && i < budget) begin
      i++;
      @(negedge clk);
      if ((is_d ? bus.d_valid : bus.if_valid) === 1'b1) cyc = i;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req/we/ifv/dv/err=%b, required 00000",
               {bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.bus_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: mem_req=%b, required 0", bus.mem_req);
    end
  endtask

  task automatic test_fetch_zero_wait;
    txn_t e;
    obs_t o;
    e.is_d = 0; e.we = 0; e.addr = 32'h40; e.wdata = '0; e.rdata = 32'h8C22_0004;
    wait_states = 0; rd_value = e.rdata;
    bus.if_addr = e.addr; bus.if_req = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.if_valid !== 1'b1 || bus.if_rdata !== e.rdata) begin
      errors++;
      $display("FAIL fetch_c1: got req=%b valid=%b rdata=%h, required 1 1 %h",
               bus.mem_req, bus.if_valid, bus.if_rdata, e.rdata);
    end
    checks++;
    if (bus.if_stall !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall: if_stall=%b in valid cycle, required 0", bus.if_stall);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2: got req=%b valid=%b, required 0 0", bus.mem_req, bus.if_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_mem: no access seen, required addr %h", e.addr);
      end else begin
        o = mem_q.pop_front();
        if ({o.we, o.addr, o.wdata} !== {e.we, e.addr, e.wdata}) begin
          errors++;
          $display("FAIL fetch_mem: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_priority;
    txn_t e;
    obs_t o;
    wait_states = 0; rd_value = 32'hCAFE_F00D;
    e.is_d = 1; e.we = 1; e.addr = 32'h100; e.wdata = 32'hDEAD_BEEF; e.rdata = '0;
    exp_q.push_back(e);
    e.is_d = 0; e.we = 0; e.addr = 32'h44; e.wdata = '0; e.rdata = rd_value;
    exp_q.push_back(e);
    bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF; bus.d_req = 1'b1;
    bus.if_addr = 32'h44; bus.if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL prio_data: got we=%b addr=%h d_valid=%b d_rdata=%h, required 1 00000100 1 00000000",
               bus.mem_we, bus.mem_addr, bus.d_valid, bus.d_rdata);
    end
    checks++;
    if (bus.if_stall !== 1'b1 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_if_stall_c1: got stall=%b valid=%b, required 1 0", bus.if_stall, bus.if_valid);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.if_stall !== 1'b1) begin
      errors++;
      $display("FAIL prio_bubble: got req=%b if_stall=%b, required 0 1", bus.mem_req, bus.if_stall);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h44 || bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL prio_fetch: got we=%b addr=%h valid=%b rdata=%h, required 0 00000044 1 cafef00d",
               bus.mem_we, bus.mem_addr, bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL prio_mem: no access seen, required addr %h", e.addr);
      end else begin
        o = mem_q.pop_front();
        if ({o.we, o.addr, o.wdata} !== {e.we, e.addr, e.wdata}) begin
          errors++;
          $display("FAIL prio_mem: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_flush;
    txn_t e;
    obs_t o;
    bit   seen_valid = 1'b0;
    bit   ack_seen = 1'b0;
    int   cyc;
    wait_states = 3; rd_value = 32'h1111_1111;
    e.is_d = 0; e.we = 0; e.addr = 32'h80; e.wdata = '0; e.rdata = rd_value;
    exp_q.push_back(e);
    bus.if_addr = 32'h80; bus.if_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.if_valid === 1'b1) seen_valid = 1'b1;
      if (bus.mem_ack === 1'b1) ack_seen = 1'b1;
      if (c == 2) bus.flush = 1'b1;
      if (c == 3) bus.flush = 1'b0;
      if (c == 4) bus.if_addr = 32'h84;
      if (c == 5) begin
        checks++;
        if (bus.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL flush_done: mem_req=%b after killed fetch ack, required 0", bus.mem_req);
        end
        bus.flush = 1'b1;
        wait_states = 1; rd_value = 32'h2222_2222;
      end
    end
    checks++;
    if (seen_valid !== 1'b0 || ack_seen !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill: got if_valid_seen=%b ack_seen=%b, required 0 1", seen_valid, ack_seen);
    end
    e.addr = 32'h84; e.rdata = rd_value;
    exp_q.push_back(e);
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h84) begin
      errors++;
      $display("FAIL flush_idle_grant: got req=%b addr=%h, required 1 00000084", bus.mem_req, bus.mem_addr);
    end
    wait_valid(1'b0, 8, cyc);
    checks++;
    if (cyc !== 1 || bus.if_rdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL flush_refetch: got valid after %0d cycles rdata=%h, required 1 22222222", cyc, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL flush_mem: no access seen, required addr %h", e.addr);
      end else begin
        o = mem_q.pop_front();
        if ({o.we, o.addr} !== {e.we, e.addr}) begin
          errors++;
          $display("FAIL flush_mem: got we=%b addr=%h, required we=%b addr=%h", o.we, o.addr, e.we, e.addr);
        end
      end
    end
  endtask

  task automatic test_load_wait;
    obs_t o;
    wait_states = 2; rd_value = 32'h1234_5678;
    bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_wdata = 32'h5555_AAAA; bus.d_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (c < 3 && (bus.d_valid !== 1'b0 || bus.d_stall !== 1'b1)) begin
        errors++;
        $display("FAIL load_wait_c%0d: got valid=%b stall=%b, required 0 1", c, bus.d_valid, bus.d_stall);
      end
      if (c == 3 && (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h1234_5678 || bus.d_stall !== 1'b0)) begin
        errors++;
        $display("FAIL load_c3: got valid=%b rdata=%h stall=%b, required 1 12345678 0",
                 bus.d_valid, bus.d_rdata, bus.d_stall);
      end
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_q.size() != 1) begin
      errors++;
      $display("FAIL load_mem: got %0d accesses, required 1", mem_q.size());
      mem_q.delete();
    end else begin
      o = mem_q.pop_front();
      if (o.we !== 1'b0 || o.addr !== 32'h200) begin
        errors++;
        $display("FAIL load_mem: got we=%b addr=%h, required 0 00000200", o.we, o.addr);
      end
    end
  endtask

  task automatic test_back_to_back;
    txn_t        e;
    obs_t        o;
    bit          first = 1'b1;
    int          n;
    int          cyc;
    logic [31:0] got;
    logic [31:0] want;
    for (int t = 0; t < 8; t++) begin
      e.is_d  = 1'($urandom_range(0, 1));
      e.we    = e.is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      e.addr  = $urandom & 32'hFFFF_FFFC;
      e.wdata = e.is_d ? $urandom : 32'h0;
      e.rdata = $urandom;
      n = int'($urandom_range(0, 2));
      wait_states = n; rd_value = e.rdata;
      if (e.is_d) begin
        bus.d_we = e.we; bus.d_addr = e.addr; bus.d_wdata = e.wdata; bus.d_req = 1'b1;
      end else begin
        bus.if_addr = e.addr; bus.if_req = 1'b1;
      end
      exp_q.push_back(e);
      wait_valid(e.is_d, 12, cyc);
      checks++;
      if (cyc !== (first ? 1 : 2) + n) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: valid after %0d cycles, required %0d", t, cyc, (first ? 1 : 2) + n);
      end
      got  = e.is_d ? bus.d_rdata : bus.if_rdata;
      want = (e.is_d && e.we) ? 32'h0 : e.rdata;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_rdata[%0d]: got %h, required %h", t, got, want);
      end
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      first = 1'b0;
    end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_mem: no access seen, required addr %h", e.addr);
      end else begin
        o = mem_q.pop_front();
        if ({o.we, o.addr, o.wdata} !== {e.we, e.addr, e.wdata}) begin
          errors++;
          $display("FAIL b2b_mem: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    hang = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      checks++;
      if (c < TO && (bus.mem_req !== 1'b1 || bus.d_valid !== 1'b0)) begin
        errors++;
        $display("FAIL wd_wait_c%0d: got req=%b valid=%b, required 1 0", c, bus.mem_req, bus.d_valid);
      end
      if (c == TO && (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0)) begin
        errors++;
        $display("FAIL wd_abort: got valid=%b rdata=%h, required 1 00000000", bus.d_valid, bus.d_rdata);
      end
    end
    bus.d_req = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_err: got req=%b bus_err=%b, required 0 1", bus.mem_req, bus.bus_err);
    end
    wait_states = 0; rd_value = 32'h0BAD_F00D;
    bus.if_addr = 32'h50; bus.if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: got if_valid=%b bus_err=%b, required 1 1", bus.if_valid, bus.bus_err);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    mem_q.delete();
`else
    repeat (10) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.d_valid !== 1'b0 || bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL nowd_hold: got req=%b valid=%b bus_err=%b, required 1 0 0",
               bus.mem_req, bus.d_valid, bus.bus_err);
    end
    bus.d_req = 1'b0;
    hang = 1'b0;
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (bus.bus_err !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wd_rst_clear: got bus_err=%b req=%b, required 0 0", bus.bus_err, bus.mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (mem_q.size() > 0) o = mem_q.pop_front();
  endtask

  task automatic test_async_reset;
    bit bad = 1'b0;
    wait_states = 5; rd_value = 32'h7777_7777;
    bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.d_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin
      errors++;
      $display("FAIL arst_pre: got req=%b addr=%h, required 1 00000400", bus.mem_req, bus.mem_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.d_valid, bus.if_valid, bus.bus_err} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL arst_now: got req/we/dv/iv/err=%b addr=%h d_rdata=%h, required 00000 0 0",
               {bus.mem_req, bus.mem_we, bus.d_valid, bus.if_valid, bus.bus_err}, bus.mem_addr, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL arst_abandon: got stray activity=%b accesses=%0d, required 0 0", bad, mem_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_priority();
    test_flush();
    test_load_wait();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "bench time limit expired");
  end
endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares the single unified memory port between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. Arbitrates with fixed data priority, sequences each access as a registered req/ack transaction, and returns per-requester stall/valid so the pipeline registers hold while the port is busy. Sits between the IF/MEM stages and the memory model, alongside the hazard detection logic whose flush it honours.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, cycles without ack before watchdog abort (>=2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; **asynchronous, active-high**
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, meaningful when if_valid
- if_valid  out  1  fetch complete, 1-cycle pulse
- if_stall  out  1  if_req & ~if_valid
- flush  in  1  kill in-flight fetch (taken branch / jump)
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, meaningful when d_valid
- d_valid  out  1  data access complete, 1-cycle pulse
- d_stall  out  1  d_req & ~d_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  access done; may be asserted the first cycle mem_req is high
- bus_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, FETCH, DATA.
- IDLE: d_req → DATA (latch d_we/d_addr/d_wdata); else if_req → FETCH (latch if_addr, mem_we=0); else stay. Simultaneous requests: DATA wins.
- FETCH/DATA: mem_req=1 from latched registers; on mem_ack → IDLE.
- FETCH + mem_ack: if_valid=1, if_rdata=mem_rdata, unless killed.
- DATA + mem_ack: d_valid=1, d_rdata=mem_rdata (loads; 0 for stores).
- Flush: flush high in any FETCH cycle (including the ack cycle) sets kill; the memory transaction still completes, if_valid suppressed, kill cleared on leaving FETCH. flush in IDLE has no effect; a concurrent if_req is granted normally.
- Requests changing while stalled are ignored (operands are latched); requesters must hold.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, kill=0, bus_err=0.
- mem_req/mem_we/mem_addr/mem_wdata registered; if_valid/d_valid/rdata combinational from mem_ack/mem_rdata in the ack cycle.
- Zero-wait memory: grant cycle 0, mem_req+ack cycle 1, IDLE cycle 2 → 2 cycles per access, 1 bubble between back-to-back accesses.
- N wait states: valid at cycle 1+N.
- rst mid-transaction: immediate return to reset values; in-flight access abandoned, no valid.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: counter clears on entering FETCH/DATA, increments each cycle without mem_ack; at TIMEOUT_CYCLES → IDLE, mem_req drops, bus_err sets (sticky until rst), owning requester gets valid pulse with rdata=0 (fetch valid still suppressed if killed).
- Undefined: no counter, bus_err tied 0, FSM waits indefinitely for mem_ack.

## Structure
- Package mem_arb_pkg: state enum (IDLE, FETCH, DATA), default widths, TIMEOUT_CYCLES default.
- Sub-module mem_arb_watchdog (enable, ack, expire) under MEM_ARB_TIMEOUT_EN; remainder in one module.

## Test plan
- Fetch only, zero-wait memory, if_addr=0x40, mem_rdata=0x8C220004 → mem_req cycle 1, if_valid+if_rdata=0x8C220004 cycle 1, mem_req=0 cycle 2.
- if_req and d_req (store, addr 0x100, wdata 0xDEADBEEF) same cycle → DATA first with mem_we=1, d_valid; FETCH granted next IDLE; if_stall high throughout.
- Fetch with 3 wait states, flush pulsed in the 2nd FETCH cycle → mem_ack honoured, if_valid never asserted, next if_req issues new fetch.
- Load, 2 wait states, mem_rdata=0x12345678 → d_valid cycle 3, d_rdata=0x12345678, d_stall low that cycle.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never → after 4 cycles mem_req drops, d_valid pulse rdata=0, bus_err=1 stays until rst.
- rst asserted asynchronously during DATA wait → all outputs reset values immediately; no d_valid.
